pp_dma_scheduler: RTL and testbench

- System-clock-side sequencer that drains one ping-pong buffer half into memory over the bus-master interface.
- Once the JTAG side has filled a half, this block:
  - swaps the halves;
  - reads the drained half word by word;
  - issues burst writes at a running destination pointer.
- Tracks progress, backpressure, overrun and bus errors.

---
 rtl/pp_dma_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_pp_dma_scheduler.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_dma_scheduler.sv
// -----------------------------------------------------------------------------
// pp_dma_scheduler
//
// System-clock-side sequencer for a ping-pong capture buffer.  When the JTAG
// side reports that one half is full, this block swaps the halves, then reads
// the drained half word by word and writes it to memory as a series of bus
// bursts starting at a running destination pointer.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   cfg_enable             block enable; a 0->1 edge loads the pointer
//   cfg_start_address      destination base address (word aligned)
//   cfg_word_count         words to drain per half (clamped to HALF_DEPTH)
//   pp_switch_req          one-cycle pulse: a half has been filled
//   pp_swap                one-cycle pulse that swaps the halves
//   buf_read_address/data  drained-half read port, 1-cycle read latency
//   bus_request/grant      bus arbitration handshake
//   bus_begin_transaction  one-cycle burst start, qualifies address/size
//   bus_address            burst start address
//   bus_burst_size         beats in the burst minus one
//   bus_byte_enable        4'hF while write data is valid
//   bus_data/data_valid    write data; a beat moves on valid & ~bus_busy
//   bus_busy, bus_error    bus backpressure and error
//   busy                   a transfer is in progress
//   transfer_done          one-cycle pulse when a half has been drained
//   error, overrun         sticky flags, cleared while cfg_enable is low
//   words_transferred      running count of accepted beats (wraps)
// -----------------------------------------------------------------------------
module pp_dma_scheduler #(
  parameter int HALF_DEPTH = 256,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [31:0]                   cfg_start_address,
  input  logic [8:0]                    cfg_word_count,
  input  logic                          pp_switch_req,
  output logic                          pp_swap,
  output logic [$clog2(HALF_DEPTH)-1:0] buf_read_address,
  input  logic [31:0]                   buf_read_data,
  output logic                          bus_request,
  input  logic                          bus_grant,
  output logic                          bus_begin_transaction,
  output logic [31:0]                   bus_address,
  output logic [7:0]                    bus_burst_size,
  output logic [3:0]                    bus_byte_enable,
  output logic [31:0]                   bus_data,
  output logic                          bus_data_valid,
  input  logic                          bus_busy,
  input  logic                          bus_error,
  output logic                          busy,
  output logic                          transfer_done,
  output logic                          error,
  output logic                          overrun,
  output logic [31:0]                   words_transferred
);

  localparam int IDX_W = $clog2(HALF_DEPTH);
  // remaining must be able to hold HALF_DEPTH itself
  localparam int REM_W = IDX_W + 1;
  // burst length must be able to hold MAX_BURST itself
  localparam int BL_W  = $clog2(MAX_BURST) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQUEST = 3'd1;
  localparam logic [2:0] S_BEGIN   = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]       state;
  logic             enable_q;
  logic [31:0]      dest_ptr;
  logic [REM_W-1:0] remaining;
  logic [IDX_W-1:0] index;
  logic [BL_W-1:0]  burst_beats;
  logic [BL_W-1:0]  beats_left;
  logic             req_q;
  logic             swap_q;
  logic             done_q;
  logic             error_q;
  logic             overrun_q;
  logic [31:0]      beat_count;

  logic [REM_W-1:0] remaining_init;
  logic [BL_W-1:0]  burst_len;
  logic             accept;

  // Words to drain for a new half, clamped to the half size.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    remaining_init = REM_W'(cfg_word_count);
    if (int'(cfg_word_count) > HALF_DEPTH) remaining_init = REM_W'(HALF_DEPTH);
  end

  // Beats in the next burst.
  always_comb begin
    burst_len = BL_W'(remaining);
    if (int'(remaining) > MAX_BURST) burst_len = BL_W'(MAX_BURST);
  end

  // A beat moves when data is presented and the bus neither stalls nor
  // errors; a beat that coincides with bus_error is not counted.
  assign accept = (state == S_DATA) && !bus_busy && !bus_error;

  // Read-port addressing.  The buffer returns data one cycle after the
  // address, so the address always points at the word that must be on
  // bus_data in the *next* cycle: the current index while stalled, the
  // following index when this cycle's beat is accepted.  BEGIN issues the
  // first prefetch so DATA starts with valid data.
  always_comb begin
    buf_read_address = '0;
    if (state == S_BEGIN) begin
      buf_read_address = index;
    end else if (state == S_DATA) begin
      buf_read_address = accept ? index + 1'b1 : index;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      enable_q    <= 1'b0;
      dest_ptr    <= '0;
      remaining   <= '0;
      index       <= '0;
      burst_beats <= '0;
      beats_left  <= '0;
      req_q       <= 1'b0;
      swap_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
      beat_count  <= '0;
    end else begin
      enable_q <= cfg_enable;
      swap_q   <= 1'b0;
      done_q   <= 1'b0;

      if (cfg_enable && !enable_q) dest_ptr <= cfg_start_address;

      // The bus has taken the beat even if the block is being disabled.
      if (accept) beat_count <= beat_count + 32'd1;

      if (!cfg_enable) begin
        state     <= S_IDLE;
        req_q     <= 1'b0;
        error_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        // Any switch request outside IDLE (DONE and ERROR included) is lost.
        if (pp_switch_req && state != S_IDLE) overrun_q <= 1'b1;

        case (state)
          S_IDLE: begin
            if (pp_switch_req) begin
              remaining <= remaining_init;
              index     <= '0;
              swap_q    <= 1'b1;
              if (remaining_init == '0) begin
                done_q <= 1'b1;
              end else begin
                state <= S_REQUEST;
                req_q <= 1'b1;
              end
            end
          end

          S_REQUEST: begin
            if (bus_error) begin
              state   <= S_ERROR;
              error_q <= 1'b1;
              req_q   <= 1'b0;
            end else if (!req_q) begin
              // Re-raise after the mandatory one-cycle gap between bursts.
              req_q <= 1'b1;
            end else if (bus_grant) begin
              state       <= S_BEGIN;
              burst_beats <= burst_len;
              beats_left  <= burst_len;
            end
          end

          S_BEGIN: begin
            if (bus_error) begin
              state   <= S_ERROR;
              error_q <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            if (bus_error) begin
              // Pointer is left alone: the failed burst is not committed.
              state   <= S_ERROR;
              error_q <= 1'b1;
              req_q   <= 1'b0;
            end else if (accept) begin
              index      <= index + 1'b1;
              remaining  <= remaining - 1'b1;
              beats_left <= beats_left - 1'b1;
              if (beats_left == BL_W'(1)) begin
                req_q    <= 1'b0;
                dest_ptr <= dest_ptr + 32'({burst_beats, 2'b00});
                if (remaining == REM_W'(1)) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= S_REQUEST;
                end
              end
            end
          end

          S_DONE:  state <= S_IDLE;
          S_ERROR: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign pp_swap               = swap_q;
  assign transfer_done         = done_q;
  assign error                 = error_q;
  assign overrun               = overrun_q;
  assign words_transferred     = beat_count;
  assign busy                  = (state != S_IDLE);

  assign bus_request           = req_q;
  assign bus_begin_transaction = (state == S_BEGIN);
  assign bus_address           = (state == S_BEGIN) ? dest_ptr : 32'd0;
  assign bus_burst_size        = (state == S_BEGIN) ? 8'(beats_left - 1'b1) : 8'd0;
  assign bus_data_valid        = (state == S_DATA);
  assign bus_byte_enable       = (state == S_DATA) ? 4'hF : 4'h0;
  // Read data is forwarded straight from the buffer; it stays stable under
  // backpressure because the read address is held while bus_busy is high.
  assign bus_data              = (state == S_DATA) ? buf_read_data : 32'd0;

endmodule

// File: tb/tb_pp_dma_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pp_dma_scheduler
//
// Bench for pp_dma_scheduler.  A bus responder/monitor runs on the falling
// edge: it drives grant, busy and error for the next rising edge and pops
// expected burst headers and beat data from scoreboard queues that the
// scenario tasks fill from a buffer/pointer model.
// -----------------------------------------------------------------------------
module tb_pp_dma_scheduler;

  localparam int HALF_DEPTH = 256;
  localparam int MAX_BURST  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_start_address = 32'd0;
  logic [8:0]  cfg_word_count = 9'd0;
  logic        pp_switch_req = 1'b0;
  logic        pp_swap;
  logic [7:0]  buf_read_address;
  logic [31:0] buf_read_data;
  logic        bus_request;
  logic        bus_grant = 1'b0;
  logic        bus_begin_transaction;
  logic [31:0] bus_address;
  logic [7:0]  bus_burst_size;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_data;
  logic        bus_data_valid;
  logic        bus_busy = 1'b0;
  logic        bus_error = 1'b0;
  logic        busy;
  logic        transfer_done;
  logic        error;
  logic        overrun;
  logic [31:0] words_transferred;

  pp_dma_scheduler #(.HALF_DEPTH(HALF_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cfg_enable            (cfg_enable),
    .cfg_start_address     (cfg_start_address),
    .cfg_word_count        (cfg_word_count),
    .pp_switch_req         (pp_switch_req),
    .pp_swap               (pp_swap),
    .buf_read_address      (buf_read_address),
    .buf_read_data         (buf_read_data),
    .bus_request           (bus_request),
    .bus_grant             (bus_grant),
    .bus_begin_transaction (bus_begin_transaction),
    .bus_address           (bus_address),
    .bus_burst_size        (bus_burst_size),
    .bus_byte_enable       (bus_byte_enable),
    .bus_data              (bus_data),
    .bus_data_valid        (bus_data_valid),
    .bus_busy              (bus_busy),
    .bus_error             (bus_error),
    .busy                  (busy),
    .transfer_done         (transfer_done),
    .error                 (error),
    .overrun               (overrun),
    .words_transferred     (words_transferred)
  );

  always #5 clock = ~clock;

  // Drained-half model with one cycle of read latency.
  logic [31:0] mem [HALF_DEPTH];
  always @(posedge clock) buf_read_data <= mem[buf_read_address];

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  size;
  } hdr_t;

  hdr_t        hdr_q[$];
  logic [31:0] data_q[$];

  int vectors     = 0;
  int miscompares = 0;

  int swap_cnt  = 0;
  int done_cnt  = 0;
  int begin_cnt = 0;
  int burst_no  = 0;
  int beat_in_burst = 0;
  int req_cycles = 0;

  int grant_delay = 0;
  bit busy_rand   = 1'b0;
  bit err_armed   = 1'b0;
  int err_burst   = 0;
  int err_beat    = 0;
  bit err_pending = 1'b0;
  bit req_dropped = 1'b1;

  logic [31:0] exp_ptr = 32'd0;
  logic [31:0] exp_wt  = 32'd0;

  // ---------------------------------------------------------------------------
  // Bus responder and monitor
  // ---------------------------------------------------------------------------
  initial begin
    hdr_t        h;
    logic [31:0] d;
    forever begin
      @(negedge clock);
      if (bus_request === 1'b1) req_cycles++; else req_cycles = 0;
      bus_grant = (bus_request === 1'b1) && (req_cycles > grant_delay);
      bus_busy  = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus_error = err_armed && (bus_data_valid === 1'b1) &&
                  (burst_no == err_burst) && (beat_in_burst == err_beat);
      if (bus_error) err_armed = 1'b0;
      #1;
      if (err_pending) begin
        vectors++;
        if ({bus_request, bus_begin_transaction, bus_data_valid, bus_byte_enable,
             bus_data, bus_address} !== '0) begin
          miscompares++;
          $display("FAIL bus_quiet_after_error: req=%b begin=%b valid=%b be=%h data=%h addr=%h, required all 0",
                   bus_request, bus_begin_transaction, bus_data_valid, bus_byte_enable, bus_data, bus_address);
        end
        err_pending = 1'b0;
      end
      if (bus_error) err_pending = 1'b1;
      if (bus_request !== 1'b1) req_dropped = 1'b1;

      if (bus_begin_transaction === 1'b1) begin
        vectors++;
        if (hdr_q.size() == 0) begin
          miscompares++;
          $display("FAIL burst_header: unexpected burst addr=%h size=%0d, required none", bus_address, bus_burst_size);
        end else begin
          h = hdr_q.pop_front();
          if (bus_address !== h.addr || bus_burst_size !== h.size) begin
            miscompares++;
            $display("FAIL burst_header: addr=%h size=%0d, required addr=%h size=%0d",
                     bus_address, bus_burst_size, h.addr, h.size);
          end
        end
        vectors++;
        if (!req_dropped) begin
          miscompares++;
          $display("FAIL request_gap: bus_request never low before burst at %h, required a low cycle", bus_address);
        end
        req_dropped = 1'b0;
        burst_no++;
        beat_in_burst = 0;
        begin_cnt++;
      end

      if (bus_data_valid === 1'b1 && !bus_busy && !bus_error) begin
        vectors++;
        if (data_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat_data: unexpected beat %h, required none", bus_data);
        end else begin
          d = data_q.pop_front();
          if (bus_data !== d || bus_byte_enable !== 4'hF) begin
            miscompares++;
            $display("FAIL beat_data: data=%h be=%h, required data=%h be=f", bus_data, bus_byte_enable, d);
          end
        end
        beat_in_burst++;
      end else if (bus_data_valid === 1'b1 && bus_busy && data_q.size() > 0) begin
        vectors++;
        if (bus_data !== data_q[0]) begin
          miscompares++;
          $display("FAIL beat_hold: data=%h under busy, required %h", bus_data, data_q[0]);
        end
      end

      if (pp_swap === 1'b1) swap_cnt++;
      if (transfer_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus and model only)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic fill_buffer(input logic [31:0] base);
    for (int i = 0; i < HALF_DEPTH; i++) mem[i] = base + 32'(i);
  endtask

  // Push expected burst headers and beats for one half drain.
  task automatic expect_transfer(input int count, input logic [31:0] base);
    int rem;
    int idx;
    int len;
    rem = (count > HALF_DEPTH) ? HALF_DEPTH : count;
    exp_wt = exp_wt + 32'(rem);
    idx = 0;
    while (rem > 0) begin
      len = (rem > MAX_BURST) ? MAX_BURST : rem;
      hdr_q.push_back('{addr: exp_ptr, size: 8'(len - 1)});
      for (int k = 0; k < len; k++) begin
        data_q.push_back(base + 32'(idx));
        idx++;
      end
      exp_ptr = exp_ptr + 32'(4 * len);
      rem = rem - len;
    end
  endtask

  task automatic pulse_switch();
    pp_switch_req = 1'b1;
    tick();
    pp_switch_req = 1'b0;
  endtask

  task automatic enable_at(input logic [31:0] addr);
    cfg_enable = 1'b0;
    tick();
    cfg_start_address = addr;
    cfg_enable = 1'b1;
    tick(2);
    exp_ptr = addr;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (done_cnt < target) begin
      miscompares++;
      $display("FAIL %s_timeout: transfer_done count %0d after %0d cycles, required %0d", name, done_cnt, n, target);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus_data_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if (bus_data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: bus_data_valid=%b, required 1", name, bus_data_valid);
    end
  endtask

  // One complete half drain with its end-of-transfer checks.
  task automatic run_drain(input string name, input int count, input logic [31:0] base,
                           input int n_bursts, input int budget);
    int s0, d0, b0;
    fill_buffer(base);
    cfg_word_count = 9'(count);
    s0 = swap_cnt; d0 = done_cnt; b0 = begin_cnt;
    expect_transfer(count, base);
    pulse_switch();
    vectors++;
    if (pp_swap !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_start: pp_swap=%b busy=%b, required 1 1", name, pp_swap, busy);
    end
    wait_done(name, d0 + 1, budget);
    tick(2);
    vectors++;
    if (swap_cnt != s0 + 1 || done_cnt != d0 + 1 || begin_cnt != b0 + n_bursts) begin
      miscompares++;
      $display("FAIL %s_counts: swaps=%0d dones=%0d bursts=%0d, required 1 1 %0d",
               name, swap_cnt - s0, done_cnt - d0, begin_cnt - b0, n_bursts);
    end
    vectors++;
    if (hdr_q.size() != 0 || data_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover: %0d headers %0d beats outstanding, required 0 0", name, hdr_q.size(), data_q.size());
    end
    vectors++;
    if (words_transferred !== exp_wt || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: words=%0d busy=%b, required words=%0d busy=0", name, words_transferred, busy, exp_wt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    vectors++;
    if ({pp_swap, bus_request, bus_begin_transaction, bus_data_valid, busy,
         transfer_done, error, overrun} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flags: swap/req/begin/valid/busy/done/err/ovr=%b, required 00000000",
               {pp_swap, bus_request, bus_begin_transaction, bus_data_valid, busy, transfer_done, error, overrun});
    end
    vectors++;
    if (words_transferred !== 32'd0 || bus_byte_enable !== 4'h0 || bus_address !== 32'd0 ||
        bus_data !== 32'd0 || bus_burst_size !== 8'd0 || buf_read_address !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values: words=%h be=%h addr=%h data=%h size=%h raddr=%h, required all 0",
               words_transferred, bus_byte_enable, bus_address, bus_data, bus_burst_size, buf_read_address);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_drain();
    enable_at(32'h0000_1000);
    run_drain("basic", 20, 32'hA000_0000, 2, 300);
    vectors++;
    if (words_transferred !== 32'd20) begin
      miscompares++;
      $display("FAIL basic_words: %0d, required 20", words_transferred);
    end
  endtask

  task automatic test_pointer_continue();
    run_drain("second", 20, 32'hB000_0000, 2, 300);
    vectors++;
    if (words_transferred !== 32'd40) begin
      miscompares++;
      $display("FAIL second_words: %0d, required 40", words_transferred);
    end
  endtask

  task automatic test_pointer_reload();
    enable_at(32'h0000_1000);
    run_drain("reload", 4, 32'h1234_0000, 1, 100);
  endtask

  task automatic test_backpressure();
    enable_at(32'h0000_1000);
    grant_delay = 5;
    busy_rand   = 1'b1;
    run_drain("backpressure", 20, 32'hD000_0000, 2, 800);
    grant_delay = 0;
    busy_rand   = 1'b0;
  endtask

  task automatic test_overrun();
    int s0, d0;
    fill_buffer(32'hE000_0000);
    cfg_word_count = 9'd20;
    s0 = swap_cnt; d0 = done_cnt;
    expect_transfer(20, 32'hE000_0000);
    pulse_switch();
    wait_valid("overrun");
    pulse_switch();
    wait_done("overrun", d0 + 1, 300);
    tick(2);
    vectors++;
    if (overrun !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_flag: overrun=%b error=%b, required 1 0", overrun, error);
    end
    vectors++;
    if (swap_cnt != s0 + 1 || hdr_q.size() != 0 || data_q.size() != 0) begin
      miscompares++;
      $display("FAIL overrun_transfer: swaps=%0d leftover=%0d/%0d, required 1 0/0",
               swap_cnt - s0, hdr_q.size(), data_q.size());
    end
    cfg_enable = 1'b0;
    tick();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
    enable_at(32'h0000_1000);
  endtask

  task automatic test_bus_error();
    int d0;
    int n;
    fill_buffer(32'h5500_0000);
    cfg_word_count = 9'd20;
    d0 = done_cnt;
    hdr_q.push_back('{addr: exp_ptr, size: 8'd15});
    for (int i = 0; i < 7; i++) data_q.push_back(32'h5500_0000 + 32'(i));
    exp_wt = exp_wt + 32'd7;
    err_burst = burst_no + 1;
    err_beat  = 7;
    err_armed = 1'b1;
    pulse_switch();
    n = 0;
    while (error !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick(3);
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL error_flag: error=%b busy=%b, required 1 0", error, busy);
    end
    vectors++;
    if (done_cnt != d0 || hdr_q.size() != 0 || data_q.size() != 0 || words_transferred !== exp_wt) begin
      miscompares++;
      $display("FAIL error_abort: dones=%0d leftover=%0d/%0d words=%0d, required 0 0/0 %0d",
               done_cnt - d0, hdr_q.size(), data_q.size(), words_transferred, exp_wt);
    end
    // The failed burst must not have moved the pointer.
    run_drain("after_error", 4, 32'h6600_0000, 1, 100);
    cfg_enable = 1'b0;
    tick();
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear: error=%b, required 0", error);
    end
    enable_at(32'h0000_1000);
  endtask

  task automatic test_zero_count();
    int s0, d0, b0;
    cfg_word_count = 9'd0;
    s0 = swap_cnt; d0 = done_cnt; b0 = begin_cnt;
    pulse_switch();
    vectors++;
    if (pp_swap !== 1'b1 || transfer_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulses: pp_swap=%b transfer_done=%b busy=%b, required 1 1 0", pp_swap, transfer_done, busy);
    end
    tick(5);
    vectors++;
    if (swap_cnt != s0 + 1 || done_cnt != d0 + 1 || begin_cnt != b0 || words_transferred !== exp_wt) begin
      miscompares++;
      $display("FAIL zero_counts: swaps=%0d dones=%0d bursts=%0d words=%0d, required 1 1 0 %0d",
               swap_cnt - s0, done_cnt - d0, begin_cnt - b0, words_transferred, exp_wt);
    end
  endtask

  task automatic test_clamped_count();
    run_drain("clamp", 300, 32'hC000_0000, 16, 1500);
  endtask

  task automatic test_reset_in_data();
    int b0;
    fill_buffer(32'h7700_0000);
    cfg_word_count = 9'd20;
    expect_transfer(20, 32'h7700_0000);
    pulse_switch();
    wait_valid("reset_data");
    reset = 1'b1;
    tick();
    vectors++;
    if ({pp_swap, bus_request, bus_begin_transaction, bus_data_valid, busy, transfer_done,
         error, overrun, bus_byte_enable} !== 12'h000 ||
        {bus_data, bus_address, words_transferred} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_in_data: req=%b valid=%b busy=%b be=%h data=%h words=%0d, required all 0",
               bus_request, bus_data_valid, busy, bus_byte_enable, bus_data, words_transferred);
    end
    reset = 1'b0;
    hdr_q.delete();
    data_q.delete();
    exp_wt = 32'd0;
    b0 = begin_cnt;
    tick(10);
    vectors++;
    if (begin_cnt != b0 || busy !== 1'b0 || bus_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_quiet: bursts=%0d busy=%b valid=%b, required 0 0 0", begin_cnt - b0, busy, bus_data_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_pointer_continue();
    test_pointer_reload();
    test_backpressure();
    test_overrun();
    test_bus_error();
    test_zero_count();
    test_clamped_count();
    test_reset_in_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
